// File: rtl/gpu_mem_pkg.sv
// Shared types and sizes for the GPU data-memory path.
package gpu_mem_pkg;

  localparam int unsigned NLANES = 4;
  localparam int unsigned AW     = 16;
  localparam int unsigned DW     = 16;
  localparam int unsigned LW     = $clog2(NLANES);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    RESP
  } lsu_state_t;

  typedef struct packed {
    logic          valid;
    logic [LW-1:0] lane;
  } lane_tag_t;

endpackage

// File: rtl/lsu_seq_if.sv
// Core-side request/response bundle of the load/store sequencer.
interface lsu_seq_if;
  import gpu_mem_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [NLANES-1:0]    req_mask;
  logic [NLANES*AW-1:0] req_addr;
  logic [NLANES*DW-1:0] req_wdata;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [NLANES*DW-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we, req_mask, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_mask, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );

endinterface

// File: rtl/lsu_lane_pick.sv
// Lowest-set-bit priority encoder over a lane mask.
module lsu_lane_pick
  import gpu_mem_pkg::*;
#(
  parameter int unsigned N  = NLANES,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  mask,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (mask[i] && !any) begin
        onehot[i] = 1'b1;
        idx       = IW'(i);
        any       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/lsu_seq.sv
// Serialises a masked vector load/store onto the single-port datamem and
// gathers load data into a per-lane response.
module lsu_seq
  import gpu_mem_pkg::*;
#(
  parameter int unsigned RD_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  lsu_seq_if.slave      core,
  output logic          mem_wren,
  output logic [AW-1:0] mem_ar,
  output logic [DW-1:0] mem_din,
  input  logic [DW-1:0] mem_q
);

  lsu_state_t           state, state_nx;
  logic                 we_q;
  logic [NLANES-1:0]    mask_q;
  logic [NLANES*AW-1:0] addr_q;
  logic [NLANES*DW-1:0] wdata_q;
  logic [NLANES*DW-1:0] rdata_q;
  logic [AW-1:0]        ar_q;
  logic [DW-1:0]        din_q;
  lane_tag_t            tag_pipe [RD_LAT];

  logic [NLANES-1:0]    pick_oh;
  logic [LW-1:0]        pick_idx;
  logic                 pick_any;
  logic                 accept, issuing, last_lane, pipe_busy;

  lsu_lane_pick #(.N(NLANES), .IW(LW)) u_pick (
    .mask   (mask_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  assign accept    = core.req_valid && (state == IDLE);
  assign issuing   = (state == ISSUE) && pick_any;
  assign last_lane = (mask_q & ~pick_oh) == '0;

  // Tags short of the last stage; the last stage retires on this edge.
  always_comb begin
    pipe_busy = 1'b0;
    for (int unsigned i = 0; i + 1 < RD_LAT; i++) begin
      pipe_busy = pipe_busy | tag_pipe[i].valid;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = (core.req_mask == '0) ? RESP : ISSUE;
      ISSUE:   if (last_lane) state_nx = we_q ? RESP : DRAIN;
      DRAIN:   if (!pipe_busy) state_nx = RESP;
      RESP:    if (core.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  assign core.req_ready = (state == IDLE);
  assign core.rsp_valid = (state == RESP);
  assign core.rsp_rdata = rdata_q;

  // The picked lane drives the port in its own issue cycle; the registered
  // copy holds the port steady outside ISSUE.
  assign mem_wren = issuing && we_q;
  assign mem_ar   = issuing ? addr_q[pick_idx*AW +: AW]  : ar_q;
  assign mem_din  = issuing ? wdata_q[pick_idx*DW +: DW] : din_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      mask_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ar_q    <= '0;
      din_q   <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      if (accept) begin
        we_q    <= core.req_we;
        mask_q  <= core.req_mask;
        addr_q  <= core.req_addr;
        wdata_q <= core.req_wdata;
        rdata_q <= '0;
      end else begin
        if (issuing) begin
          mask_q <= mask_q & ~pick_oh;
          ar_q   <= mem_ar;
          din_q  <= mem_din;
        end
        if (tag_pipe[RD_LAT-1].valid) begin
          rdata_q[tag_pipe[RD_LAT-1].lane*DW +: DW] <= mem_q;
        end
      end
      tag_pipe[0] <= '{valid: issuing && !we_q, lane: pick_idx};
      for (int unsigned i = 1; i < RD_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

endmodule

// File: tb/tb_lsu_seq.sv
// Bench for lsu_seq: directed scenarios plus random transactions against a
// lane-list reference model and a behavioural datamem.
module tb_lsu_seq;
  import gpu_mem_pkg::*;

  localparam int RD_LAT = 1;

  typedef struct packed {
    logic                 we;
    logic [NLANES-1:0]    mask;
    logic [NLANES*AW-1:0] addr;
    logic [NLANES*DW-1:0] wdata;
  } req_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mem_wren;
  logic [AW-1:0] mem_ar;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_q;

  always #5 clk = ~clk;

  lsu_seq_if bus();

  lsu_seq #(.RD_LAT(RD_LAT)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .core     (bus),
    .mem_wren (mem_wren),
    .mem_ar   (mem_ar),
    .mem_din  (mem_din),
    .mem_q    (mem_q)
  );

  // datamem: synchronous read-first, one cycle read latency, mem[a]=a+1 at start
  logic [DW-1:0] mem [65536];
  bit            mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int a = 0; a < 65536; a++) mem[a] <= DW'(a + 1);
      mem_init <= 1'b1;
    end else if (mem_wren) begin
      mem[mem_ar] <= mem_din;
    end
    mem_q <= mem[mem_ar];
  end

  logic [DW-1:0] ref_mem [65536];
  logic [AW-1:0] exp_ar  = '0;
  logic [DW-1:0] exp_din = '0;
  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input req_t r);
    bus.req_valid = 1'b1;
    bus.req_we    = r.we;
    bus.req_mask  = r.mask;
    bus.req_addr  = r.addr;
    bus.req_wdata = r.wdata;
  endtask

  // Called at a negedge; returns at the negedge one cycle after the response handshake.
  task automatic txn(input req_t r, input int hold, input bit pend, input req_t nx);
    int            order[$];
    int            k, lat, n, ln;
    bit            seen;
    logic [63:0]   exp_rd;
    logic [AW-1:0] a;
    exp_rd = '0;
    for (int i = 0; i < NLANES; i++) if (r.mask[i]) order.push_back(i);
    k = order.size();
    lat = (k == 0) ? 1 : (r.we ? k + 1 : k + RD_LAT + 1);
    foreach (order[j]) begin
      ln = order[j];
      a  = r.addr[ln*AW +: AW];
      if (r.we) ref_mem[a] = r.wdata[ln*DW +: DW];
      else      exp_rd[ln*DW +: DW] = ref_mem[a];
    end

    bus.rsp_ready = (hold == 0);
    drive_req(r);
    chk("req_ready_at_accept", bus.req_ready, 1);
    @(posedge clk);
    seen = 1'b0;
    for (n = 1; n <= 64; n++) begin
      @(negedge clk);
      if (n == 1) bus.req_valid = 1'b0;
      if (bus.rsp_valid) begin
        seen = 1'b1;
        break;
      end
      if (n <= k) begin
        ln = order[n-1];
        exp_ar  = r.addr[ln*AW +: AW];
        exp_din = r.wdata[ln*DW +: DW];
        chk("issue_wren", mem_wren, r.we);
      end else begin
        chk("drain_wren", mem_wren, 0);
      end
      chk("port_ar", mem_ar, exp_ar);
      chk("port_din", mem_din, exp_din);
      chk("busy_req_ready", bus.req_ready, 0);
    end
    chk("rsp_latency", seen ? n : 0, lat);
    if (!seen) return;
    chk("rsp_rdata", bus.rsp_rdata, exp_rd);
    chk("rsp_req_ready", bus.req_ready, 0);
    chk("rsp_wren", mem_wren, 0);
    chk("rsp_ar_hold", mem_ar, exp_ar);
    for (int h = 0; h < hold - 1; h++) begin
      if (pend) drive_req(nx);
      @(negedge clk);
      chk("hold_rsp_valid", bus.rsp_valid, 1);
      chk("hold_rsp_rdata", bus.rsp_rdata, exp_rd);
      chk("hold_req_ready", bus.req_ready, 0);
    end
    if (pend) drive_req(nx);
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("post_rsp_valid", bus.rsp_valid, 0);
    chk("post_req_ready", bus.req_ready, 1);
  endtask

  initial begin
    req_t r, nx;
    for (int a = 0; a < 65536; a++) ref_mem[a] = DW'(a + 1);
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_mask  = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_req_ready", bus.req_ready, 1);
    chk("reset_rsp_valid", bus.rsp_valid, 0);
    chk("reset_rsp_rdata", bus.rsp_rdata, 0);
    chk("reset_wren", mem_wren, 0);
    chk("reset_ar", mem_ar, 0);
    chk("reset_din", mem_din, 0);

    // Full-mask load of addresses 0..3
    r = '{we: 1'b0, mask: 4'b1111, addr: {16'd3, 16'd2, 16'd1, 16'd0}, wdata: 64'h1111_2222_3333_4444};
    txn(r, 0, 0, r);
    // Sparse load, lanes 0 and 2 only
    r = '{we: 1'b0, mask: 4'b0101, addr: {16'hFFFF, 16'h0020, 16'hFFFF, 16'h0010}, wdata: '0};
    txn(r, 1, 0, r);
    // Same-address store: lane 3 must win
    r = '{we: 1'b1, mask: 4'b1111, addr: {4{16'h0005}}, wdata: {16'hD, 16'hC, 16'hB, 16'hA}};
    txn(r, 0, 0, r);
    r = '{we: 1'b0, mask: 4'b0001, addr: {48'h0, 16'h0005}, wdata: '0};
    txn(r, 0, 0, r);
    // Empty masks
    r = '{we: 1'b0, mask: 4'b0000, addr: {4{16'h0077}}, wdata: '1};
    txn(r, 0, 0, r);
    r = '{we: 1'b1, mask: 4'b0000, addr: {4{16'h0088}}, wdata: '1};
    txn(r, 2, 0, r);
    // Stalled response with the next request already pending
    r  = '{we: 1'b0, mask: 4'b0011, addr: {16'h0, 16'h0, 16'h0007, 16'h0006}, wdata: '0};
    nx = '{we: 1'b0, mask: 4'b1000, addr: {16'h0009, 48'h0}, wdata: '0};
    txn(r, 5, 1, nx);
    txn(nx, 0, 0, nx);

    // Reset during the second issue cycle of a 4-lane store
    r = '{we: 1'b1, mask: 4'b1111, addr: {16'h0103, 16'h0102, 16'h0101, 16'h0100},
          wdata: {16'hBEE3, 16'hBEE2, 16'hBEE1, 16'hBEE0}};
    bus.rsp_ready = 1'b0;
    drive_req(r);
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("rst_lane0_ar", mem_ar, 16'h0100);
    @(posedge clk);
    #2;
    chk("rst_lane1_wren", mem_wren, 1);
    chk("rst_lane1_ar", mem_ar, 16'h0101);
    rst_n = 1'b0;
    #1;
    chk("rst_wren_drop", mem_wren, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_ar_clear", mem_ar, 0);
    @(negedge clk);
    rst_n = 1'b1;
    ref_mem[16'h0100] = 16'hBEE0;
    exp_ar  = '0;
    exp_din = '0;
    @(negedge clk);
    chk("rst_release_ready", bus.req_ready, 1);
    chk("rst_release_rsp", bus.rsp_valid, 0);
    chk("rst_release_rdata", bus.rsp_rdata, 0);
    r = '{we: 1'b0, mask: 4'b1111, addr: {16'h0103, 16'h0102, 16'h0101, 16'h0100}, wdata: '0};
    txn(r, 0, 0, r);

    // Random traffic over a small address window to force aliasing
    for (int t = 0; t < 40; t++) begin
      r.we    = 1'($urandom_range(0, 1));
      r.mask  = 4'($urandom);
      for (int i = 0; i < NLANES; i++) begin
        r.addr[i*AW +: AW]  = 16'($urandom_range(0, 31));
        r.wdata[i*DW +: DW] = 16'($urandom);
      end
      txn(r, int'($urandom_range(0, 3)), 0, r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
